rstseq: RTL and testbench

Reset sequencer that sits directly downstream of the asynchronous-assert/synchronous-release reset synchronizer. It holds NDOM reset domains (core, caches, bus fabric, peripherals, etc.) in reset, then releases them one at a time in ascending index order. Before releasing the next domain, it waits for each released domain to report ready. It also services software or debug requests to re-reset a selected subset of domains with the same ordered release.

---
 rtl/rstseq.sv | 139 +++++++++++++
 tb/tb_rstseq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rstseq.sv
// Ordered reset release sequencer with software re-reset.
// Optional ready-wait timeout: define RSTSEQ_TIMEOUT_EN.
module rstseq #(
   parameter int NDOM       = 4,
   parameter int HOLDCYCLES = 16,
   parameter int GAPCYCLES  = 2,
   parameter int TIMEOUT    = 256
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            SwResetReq,
   input  logic [NDOM-1:0] SwResetMask,
   input  logic [NDOM-1:0] DomainReady,
   output logic [NDOM-1:0] DomainReset,
   output logic            SeqBusy,
   output logic            SeqDone,
   output logic [NDOM-1:0] TimeoutErr
);

   localparam int M1   = (HOLDCYCLES > GAPCYCLES) ? HOLDCYCLES : GAPCYCLES;
   localparam int MAXC = (M1 > TIMEOUT) ? M1 : TIMEOUT;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam int IW   = (NDOM > 1) ? $clog2(NDOM) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   logic [1:0]      state;
   logic [CW-1:0]   Cnt;
   logic [IW-1:0]   Idx;
   logic [NDOM-1:0] Mask;

   logic            has_nxt;
   logic [IW-1:0]   nxt_idx;
   logic [IW-1:0]   req_idx;
   logic            rdy;
   logic            adv;
   logic            hold_end;
   logic            gap_end;

   // Next masked domain above Idx, and lowest bit of a new request mask
   always_comb begin
      has_nxt = 1'b0;
      nxt_idx = '0;
      req_idx = '0;
      for (int j = NDOM - 1; j >= 0; j--) begin
         if (Mask[j] && (j > int'(Idx))) begin
            has_nxt = 1'b1;
            nxt_idx = IW'(j);
         end
         if (SwResetMask[j]) req_idx = IW'(j);
      end
   end

   assign rdy      = DomainReady[Idx];
   assign hold_end = (Cnt == CW'(HOLDCYCLES - 1));
   assign gap_end  = (Cnt == CW'(GAPCYCLES - 1));

`ifdef RSTSEQ_TIMEOUT_EN
   logic tmo;
   assign tmo = !rdy && (Cnt == CW'(TIMEOUT - 1));
   assign adv = rdy || tmo;
`else
   assign adv = rdy;
   assign TimeoutErr = '0;
`endif

   // Sequencer state, per-domain resets and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= HOLD;
         DomainReset <= '1;
         Mask        <= '1;
         Idx         <= '0;
         Cnt         <= '0;
         SeqBusy     <= 1'b1;
         SeqDone     <= 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
         TimeoutErr  <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (SwResetReq && (SwResetMask != '0)) begin
                  DomainReset <= DomainReset | SwResetMask;
                  Mask        <= SwResetMask;
                  Idx         <= req_idx;
                  Cnt         <= '0;
`ifdef RSTSEQ_TIMEOUT_EN
                  TimeoutErr  <= TimeoutErr & ~SwResetMask;
`endif
                  SeqBusy     <= 1'b1;
                  SeqDone     <= 1'b0;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (hold_end) begin
                  DomainReset[Idx] <= 1'b0;
                  Cnt              <= '0;
                  state            <= WAIT;
               end else begin
                  Cnt <= Cnt + 1'b1;
               end
            end
            WAIT: begin
`ifdef RSTSEQ_TIMEOUT_EN
               if (tmo) TimeoutErr[Idx] <= 1'b1;
               else if (!rdy) Cnt <= Cnt + 1'b1;
`endif
               if (adv) begin
                  if (has_nxt) begin
                     Idx   <= nxt_idx;
                     Cnt   <= '0;
                     state <= GAP;
                  end else begin
                     SeqBusy <= 1'b0;
                     SeqDone <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_end) begin
                  DomainReset[Idx] <= 1'b0;
                  Cnt              <= '0;
                  state            <= WAIT;
               end else begin
                  Cnt <= Cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rstseq.sv
// Scoreboard bench for rstseq: edge-stamped expectations
// checked by a negedge monitor.
module tb_rstseq;

`ifdef RSTSEQ_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 256;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       SwResetReq = 1'b0;
   logic [3:0] SwResetMask = 4'b0000;
   logic [3:0] DomainReady = 4'b1111;
   logic [3:0] DomainReset;
   logic       SeqBusy;
   logic       SeqDone;
   logic [3:0] TimeoutErr;

   rstseq #(
      .NDOM(4), .HOLDCYCLES(16), .GAPCYCLES(2), .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .SwResetReq(SwResetReq),
      .SwResetMask(SwResetMask),
      .DomainReady(DomainReady),
      .DomainReset(DomainReset),
      .SeqBusy(SeqBusy),
      .SeqDone(SeqDone),
      .TimeoutErr(TimeoutErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         e;
      int         f;
      logic [3:0] v;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   ecnt = 0;
   int   checks = 0;
   int   errors = 0;

   // Edge count since reset release
   always @(posedge clk) begin
      if (reset) ecnt <= 0;
      else ecnt <= ecnt + 1;
   end

   task automatic chk(input string nm, input logic [3:0] a,
                      input logic [3:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s @edge %0d: got %b expected %b", nm, ecnt, a, x);
      end
   endtask

   function automatic logic [3:0] sel(input int f);
      case (f)
         0:       return DomainReset;
         1:       return {3'b000, SeqBusy};
         2:       return {3'b000, SeqDone};
         default: return TimeoutErr;
      endcase
   endfunction

   function automatic void ex(input int e, input int f,
                              input logic [3:0] v, input string nm);
      exp_t it;
      int   p;
      it.e = e; it.f = f; it.v = v; it.nm = nm;
      p = q.size();
      while (p > 0 && q[p-1].e > e) p--;
      q.insert(p, it);
   endfunction

   // Monitor: pops expectations due at the current edge
   always @(negedge clk) begin
      if (!reset) begin
         while (q.size() > 0 && q[0].e <= ecnt) begin
            exp_t it;
            it = q.pop_front();
            if (it.e < ecnt) begin
               checks++;
               errors++;
               $display("FAIL %s: missed edge %0d", it.nm, it.e);
            end else begin
               chk(it.nm, sel(it.f), it.v);
            end
         end
      end
   end

   task automatic at_edge(input int n);
      int g = 0;
      while (ecnt != n && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (ecnt != n) begin
         checks++;
         errors++;
         $display("FAIL wait_edge: got %0d expected %0d", ecnt, n);
      end
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() > 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      // Power-on sequence
      DomainReady = 4'b1111;
      do_reset();
      ex(0, 0, 4'b1111, "po_rst_dr");
      ex(0, 1, 4'b0001, "po_rst_busy");
      ex(0, 2, 4'b0000, "po_rst_done");
      ex(0, 3, 4'b0000, "po_rst_terr");
      ex(15, 0, 4'b1111, "po_hold15");
      ex(16, 0, 4'b1110, "po_rel0");
      ex(18, 0, 4'b1110, "po_gap18");
      ex(19, 0, 4'b1100, "po_rel1");
      ex(22, 0, 4'b1000, "po_rel2");
      ex(25, 0, 4'b0000, "po_rel3");
      ex(25, 2, 4'b0000, "po_done25");
      ex(26, 1, 4'b0000, "po_busy26");
      ex(26, 2, 4'b0001, "po_done26");
      ex(26, 3, 4'b0000, "po_terr26");
      drain();

      // Reset asserted mid-sequence
      do_reset();
      ex(19, 0, 4'b1100, "mid_pre");
      at_edge(20);
      reset = 1'b1;
      #1;
      chk("mid_async_dr", DomainReset, 4'b1111);
      chk("mid_async_busy", {3'b000, SeqBusy}, 4'b0001);
      chk("mid_async_done", {3'b000, SeqDone}, 4'b0000);
      drain();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      ex(15, 0, 4'b1111, "mid_hold15");
      ex(16, 0, 4'b1110, "mid_rel0");
      ex(19, 0, 4'b1100, "mid_rel1");
      ex(26, 2, 4'b0001, "mid_done");
      drain();

`ifndef RSTSEQ_TIMEOUT_EN
      // Ready backpressure on domain 1
      DomainReady = 4'b1101;
      do_reset();
      ex(19, 0, 4'b1100, "bp_rel1");
      ex(39, 0, 4'b1100, "bp_wait39");
      ex(42, 0, 4'b1100, "bp_not42");
      ex(43, 0, 4'b1000, "bp_rel2");
      ex(46, 0, 4'b0000, "bp_rel3");
      ex(47, 2, 4'b0001, "bp_done");
      at_edge(40);
      DomainReady = 4'b1111;
      drain();
`endif

      // Software re-reset of domains 1 and 3
      DomainReady = 4'b1111;
      do_reset();
      ex(99, 0, 4'b0000, "sw_pre_dr");
      ex(99, 2, 4'b0001, "sw_pre_done");
      ex(100, 0, 4'b1010, "sw_acc_dr");
      ex(100, 1, 4'b0001, "sw_acc_busy");
      ex(100, 2, 4'b0000, "sw_acc_done");
      ex(105, 0, 4'b1010, "sw_busyreq105");
      ex(106, 0, 4'b1010, "sw_busyreq106");
      ex(115, 0, 4'b1010, "sw_hold115");
      ex(116, 0, 4'b1000, "sw_rel1");
      ex(118, 0, 4'b1000, "sw_gap118");
      ex(119, 0, 4'b0000, "sw_rel3");
      ex(120, 1, 4'b0000, "sw_busy120");
      ex(120, 2, 4'b0001, "sw_done120");
      ex(131, 0, 4'b0000, "sw_zero_dr");
      ex(131, 1, 4'b0000, "sw_zero_busy");
      ex(131, 2, 4'b0001, "sw_zero_done");
      at_edge(99);
      SwResetReq = 1'b1; SwResetMask = 4'b1010;
      at_edge(100);
      SwResetReq = 1'b0; SwResetMask = 4'b0000;
      at_edge(104);
      SwResetReq = 1'b1; SwResetMask = 4'b0101;
      at_edge(105);
      SwResetReq = 1'b0; SwResetMask = 4'b0000;
      at_edge(129);
      SwResetReq = 1'b1; SwResetMask = 4'b0000;
      at_edge(130);
      SwResetReq = 1'b0;
      drain();

`ifdef RSTSEQ_TIMEOUT_EN
      // Domain 0 never ready: timeout then proceed
      DomainReady = 4'b1110;
      do_reset();
      ex(16, 0, 4'b1110, "to_rel0");
      ex(23, 3, 4'b0000, "to_pre");
      ex(24, 3, 4'b0001, "to_set");
      ex(26, 0, 4'b1100, "to_rel1");
      ex(33, 2, 4'b0001, "to_done");
      ex(39, 3, 4'b0001, "to_sticky");
      ex(40, 3, 4'b0000, "to_clr");
      ex(40, 0, 4'b0001, "to_sw_dr");
      ex(56, 0, 4'b0000, "to_sw_rel");
      ex(57, 2, 4'b0001, "to_sw_done");
      at_edge(38);
      DomainReady = 4'b1111;
      at_edge(39);
      SwResetReq = 1'b1; SwResetMask = 4'b0001;
      at_edge(40);
      SwResetReq = 1'b0; SwResetMask = 4'b0000;
      drain();

      // Ready arrives on the timeout cycle: no flag
      DomainReady = 4'b1110;
      do_reset();
      ex(24, 3, 4'b0000, "tie_24");
      ex(26, 0, 4'b1100, "tie_rel1");
      ex(27, 3, 4'b0000, "tie_27");
      at_edge(23);
      DomainReady = 4'b1111;
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
